s2_serial_rx: RTL

- Receiving end of the serial link driven by the ROM-to-serial sender (`sen`/`sd`).
- Each frame is a 3-bit word address followed by an 18-bit data word, both MSB first, sent while `sen` is low.
- The block deserializes each frame and writes the word into RAM RB2 at the received address.
- After 8 good frames it raises `S2_done`.

---
 rtl/s2_serial_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/s2_serial_rx.sv
// Serial frame receiver: deserializes {address, data} frames sent MSB first
// while sen is low and writes each complete frame into RB2.
module s2_serial_rx #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 18,
  parameter int FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  output logic              S2_done,
  output logic              frame_err
);

  localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int FCNT_W = $clog2(FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ADDR_W-1:0]   addr_sr_q,   addr_sr_d;
  logic [DATA_W-1:0]   data_sr_q,   data_sr_d;
  logic [ADDR_W-1:0]   rb2_a_q,     rb2_a_d;
  logic [DATA_W-1:0]   rb2_d_q,     rb2_d_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    rb2_a_d     = rb2_a_q;
    rb2_d_d     = rb2_d_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (!sen) begin
          addr_sr_d = (addr_sr_q << 1) | ADDR_W'(sd);
          bit_cnt_d = CNT_W'(1);
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (sen) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bit_cnt_q == CNT_W'(ADDR_W)) begin
          // Address complete: this sample is the data MSB.
          data_sr_d = (data_sr_q << 1) | DATA_W'(sd);
          bit_cnt_d = CNT_W'(1);
          state_d   = (DATA_W == 1) ? S_WRITE : S_DATA;
        end else begin
          addr_sr_d = (addr_sr_q << 1) | ADDR_W'(sd);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (sen) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          data_sr_d = (data_sr_q << 1) | DATA_W'(sd);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        // A low sen here means the sender skipped its gap; that bit is lost.
        if (!sen) err_d = 1'b1;
        if (frame_cnt_q == FCNT_W'(FRAMES - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (sen) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (sen) state_d = S_IDLE;
        else     err_d   = 1'b1;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Write port registers load on entry to WRITE and hold afterwards.
    if (state_d == S_WRITE) begin
      rb2_a_d = addr_sr_d;
      rb2_d_d = data_sr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      rb2_a_q     <= '0;
      rb2_d_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      rb2_a_q     <= rb2_a_d;
      rb2_d_q     <= rb2_d_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign RB2_RW    = (state_q != S_WRITE);
  assign RB2_A     = rb2_a_q;
  assign RB2_D     = rb2_d_q;
  assign S2_done   = done_q;
  assign frame_err = err_q;

endmodule
